// File: rtl/simmem_pkg.sv
// Shared constants and types for the write-response delay releaser.
// The optional occupancy counter is enabled with SIMMEM_RELEASER_PENDING_CNT_EN.
package simmem_pkg;

  localparam int WriteRespBankTotalCapacity = 16;
  localparam int WriteRespBankAddrWidth     = $clog2(WriteRespBankTotalCapacity);
  localparam int DelayWidth                 = 8;

  typedef enum logic [1:0] {
    SlotIdle,
    SlotCounting,
    SlotEligible
  } slot_state_e;

  typedef logic [DelayWidth-1:0] delay_t;

endpackage

// File: rtl/simmem_delay_slot.sv
// One tracked bank address: IDLE -> COUNTING -> ELIGIBLE -> IDLE.
// Eligibility is asserted max(delay,1) cycles after the load cycle.
module simmem_delay_slot
  import simmem_pkg::*;
#(
  parameter int DelayWidth = simmem_pkg::DelayWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DelayWidth-1:0] delay_i,
  input  logic                  release_i,
  output logic                  eligible_o,
  output logic                  idle_o
);

  slot_state_e           r_state;
  slot_state_e           w_state_next;
  logic [DelayWidth-1:0] r_count;
  logic [DelayWidth-1:0] w_count_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SlotIdle;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // The load cycle itself counts as the first elapsed cycle, so the counter
  // holds delay-1 on entry to COUNTING; delays of 0 and 1 skip COUNTING.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    unique case (r_state)
      SlotIdle: begin
        if (load_i) begin
          if (delay_i > DelayWidth'(1)) begin
            w_state_next = SlotCounting;
            w_count_next = delay_i - DelayWidth'(1);
          end else begin
            w_state_next = SlotEligible;
            w_count_next = '0;
          end
        end
      end
      SlotCounting: begin
        if (r_count == DelayWidth'(1)) begin
          w_state_next = SlotEligible;
          w_count_next = '0;
        end else begin
          w_count_next = r_count - DelayWidth'(1);
        end
      end
      SlotEligible: begin
        if (release_i) begin
          w_state_next = SlotIdle;
        end
      end
      default: begin
        w_state_next = SlotIdle;
        w_count_next = '0;
      end
    endcase
  end

  assign eligible_o = (r_state == SlotEligible);
  assign idle_o     = (r_state == SlotIdle);

endmodule

// File: rtl/simmem_wresp_delay_releaser.sv
// Per-slot delay tracker gating the write-response bank's release enables.
// Define SIMMEM_RELEASER_PENDING_CNT_EN to add the num_pending_o occupancy counter.
module simmem_wresp_delay_releaser
  import simmem_pkg::*;
#(
  parameter int NumSlots      = WriteRespBankTotalCapacity,
  parameter int SlotAddrWidth = WriteRespBankAddrWidth,
  parameter int DelayWidth    = simmem_pkg::DelayWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     entry_valid_i,
  output logic                     entry_ready_o,
  input  logic [SlotAddrWidth-1:0] entry_addr_i,
  input  logic [DelayWidth-1:0]    entry_delay_i,
  output logic [NumSlots-1:0]      release_en_o,
  input  logic [NumSlots-1:0]      released_addr_onehot_i
`ifdef SIMMEM_RELEASER_PENDING_CNT_EN
  ,
  output logic [$clog2(NumSlots+1)-1:0] num_pending_o
`endif
);

  logic [NumSlots-1:0] w_addr_hit;
  logic [NumSlots-1:0] w_load;
  logic [NumSlots-1:0] w_idle;
  logic [NumSlots-1:0] w_eligible;
  logic                w_handshake;

  // An out-of-range address matches no slot, so ready stays low and it stalls.
  assign entry_ready_o = rst_ni && |(w_addr_hit & w_idle);
  assign w_handshake   = entry_valid_i && entry_ready_o;
  assign release_en_o  = w_eligible;

  for (genvar gi = 0; gi < NumSlots; gi++) begin : g_slot
    assign w_addr_hit[gi] = (entry_addr_i == SlotAddrWidth'(gi));
    assign w_load[gi]     = w_handshake && w_addr_hit[gi];

    simmem_delay_slot #(
      .DelayWidth (DelayWidth)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (w_load[gi]),
      .delay_i    (entry_delay_i),
      .release_i  (released_addr_onehot_i[gi]),
      .eligible_o (w_eligible[gi]),
      .idle_o     (w_idle[gi])
    );
  end

`ifdef SIMMEM_RELEASER_PENDING_CNT_EN
  localparam int PendW = $clog2(NumSlots + 1);

  logic [PendW-1:0]    r_num_pending;
  logic [PendW-1:0]    w_release_cnt;
  logic [NumSlots-1:0] w_honoured;

  // Only releases that hit an ELIGIBLE slot actually free it.
  assign w_honoured = released_addr_onehot_i & w_eligible;

  always_comb begin
    w_release_cnt = '0;
    for (int i = 0; i < NumSlots; i++) begin
      w_release_cnt = w_release_cnt + PendW'(w_honoured[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_num_pending <= '0;
    end else begin
      r_num_pending <= r_num_pending + PendW'(w_handshake) - w_release_cnt;
    end
  end

  assign num_pending_o = r_num_pending;
`endif

endmodule
